// File: rtl/six_digit_display_scanner_if.sv
// Bus between the lock controller and the six-digit display scanner.
// The dp_mask signal exists only when SCANNER_DP_EN is defined.
interface six_digit_display_scanner_if;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] d4;
    logic [3:0] d5;
    logic [3:0] d6;
    logic       hide;
    logic       blink;
`ifdef SCANNER_DP_EN
    logic [5:0] dp_mask;
`endif
    logic [7:0] seg;
    logic [5:0] an;
    logic       frame_tick;

`ifdef SCANNER_DP_EN
    modport master (
        output d1, d2, d3, d4, d5, d6, hide, blink, dp_mask,
        input  seg, an, frame_tick
    );
    modport slave (
        input  d1, d2, d3, d4, d5, d6, hide, blink, dp_mask,
        output seg, an, frame_tick
    );
`else
    modport master (
        output d1, d2, d3, d4, d5, d6, hide, blink,
        input  seg, an, frame_tick
    );
    modport slave (
        input  d1, d2, d3, d4, d5, d6, hide, blink,
        output seg, an, frame_tick
    );
`endif
endinterface

// File: rtl/six_digit_display_scanner.sv
// Six-digit common-anode display scanner: frame snapshot, 7-seg decode, dead-time, blink.
// Optional macro SCANNER_DP_EN adds a per-digit decimal-point mask latched with the snapshot.
module six_digit_display_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD         = 500,
    parameter int BLINK_FRAMES = 64,
    parameter int DIV_W        = 16
) (
    input logic                        clk,
    input logic                        clr_n,
    six_digit_display_scanner_if.slave bus
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Counters hold the index of the cycle about to start, so every output
    // register loaded at an edge already shows that cycle's value.
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_slot;
    state_t           r_state;
    state_t           w_state_next;

    logic [3:0]       r_snap [6];
    logic             r_hide;
`ifdef SCANNER_DP_EN
    logic [5:0]       r_dp;
`endif

    logic [FC_W-1:0]  r_fcnt;
    logic             r_phase;
    logic             r_blink_l;
    logic             r_force;

    logic [7:0]       r_seg;
    logic [5:0]       r_an;
    logic             r_tick;

    logic             w_last;
    logic             w_frame_start;
    logic [3:0]       w_code;
    logic             w_hide_cur;
    logic             w_dp_bit;
    logic [FC_W-1:0]  w_fcnt_next;
    logic             w_phase_next;
    logic             w_blink_l_next;
    logic             w_force_next;
    logic             w_drive;
    logic [7:0]       w_seg_next;
    logic [5:0]       w_an_next;

    function automatic logic [6:0] decode(input logic [3:0] code, input logic hide);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            4'd14:   pat = 7'h06;
            4'd15:   pat = 7'h7F;
            default: pat = 7'h3F;
        endcase
        if (hide && (code < 4'd14)) begin
            pat = 7'h3F;
        end
        return pat;
    endfunction

    assign w_last        = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_frame_start = (r_slot == 3'd0) && (r_div == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_div  <= '0;
            r_slot <= 3'd0;
        end else if (w_last) begin
            r_div  <= '0;
            r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // At a frame start the fresh bus values are used directly, so slot 0 is
    // correct even when there is no dead time.
    always_comb begin
        w_code     = r_snap[r_slot];
        w_hide_cur = r_hide;
        if (w_frame_start) begin
            w_code     = bus.d1;
            w_hide_cur = bus.hide;
        end
    end

`ifdef SCANNER_DP_EN
    always_comb begin
        w_dp_bit = ~r_dp[r_slot];
        if (w_frame_start) begin
            w_dp_bit = ~bus.dp_mask[0];
        end
    end
`else
    assign w_dp_bit = 1'b1;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 6; i++) begin
                r_snap[i] <= 4'hF;
            end
            r_hide <= 1'b0;
        end else if (w_frame_start) begin
            r_snap[0] <= bus.d1;
            r_snap[1] <= bus.d2;
            r_snap[2] <= bus.d3;
            r_snap[3] <= bus.d4;
            r_snap[4] <= bus.d5;
            r_snap[5] <= bus.d6;
            r_hide    <= bus.hide;
        end
    end

`ifdef SCANNER_DP_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_dp <= 6'h00;
        end else if (w_frame_start) begin
            r_dp <= bus.dp_mask;
        end
    end
`endif

    // The frame counter only advances when the previous frame also began with
    // blink high, so the first blinking frame starts a full lit half-period.
    always_comb begin
        w_fcnt_next    = r_fcnt;
        w_phase_next   = r_phase;
        w_blink_l_next = r_blink_l;
        w_force_next   = r_force;
        if (!bus.blink) begin
            w_fcnt_next  = '0;
            w_phase_next = 1'b0;
        end
        if (w_frame_start) begin
            if (bus.blink && r_blink_l) begin
                if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
                    w_fcnt_next  = '0;
                    w_phase_next = ~r_phase;
                end else begin
                    w_fcnt_next  = r_fcnt + 1'b1;
                end
            end
            w_blink_l_next = bus.blink;
            w_force_next   = bus.blink && w_phase_next;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_fcnt    <= '0;
            r_phase   <= 1'b0;
            r_blink_l <= 1'b0;
            r_force   <= 1'b0;
        end else begin
            r_fcnt    <= w_fcnt_next;
            r_phase   <= w_phase_next;
            r_blink_l <= w_blink_l_next;
            r_force   <= w_force_next;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_drive      = 1'b0;
        w_an_next    = 6'h3F;
        w_seg_next   = 8'hFF;
        case (r_state)
            ST_BLANK: begin
                if (r_div == DIV_W'(DEAD)) begin
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if ((r_div == '0) && (DEAD != 0)) begin
                    w_state_next = ST_BLANK;
                end
            end
            default: w_state_next = ST_BLANK;
        endcase
        w_drive = (w_state_next == ST_DRIVE);
        if (w_drive) begin
            w_seg_next = {w_dp_bit, decode(w_code, w_hide_cur)};
            if (!w_force_next) begin
                w_an_next = ~(6'b000001 << r_slot);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_seg  <= 8'hFF;
            r_an   <= 6'h3F;
            r_tick <= 1'b0;
        end else begin
            r_seg  <= w_seg_next;
            r_an   <= w_an_next;
            r_tick <= w_frame_start;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_six_digit_display_scanner.sv
// Directed and randomized bench for six_digit_display_scanner with a cycle-indexed reference model.
module tb_six_digit_display_scanner;

  localparam int SCAN_DIV     = 8;
  localparam int DEAD         = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 6 * SCAN_DIV;

  logic clk = 1'b0;
  logic clr_n = 1'b0;

  six_digit_display_scanner_if u_if ();

  six_digit_display_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEAD        (DEAD),
    .BLINK_FRAMES(BLINK_FRAMES),
    .DIV_W       (4)
  ) u_dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: t is the index of the cycle currently shown
  int         t;
  logic [3:0] m_snap [6];
  logic       m_hide;
  logic [5:0] m_dp;
  int         m_k;
  bit         m_dark;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06, 7'h7F};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic set_digits(input int a, input int b, input int c, input int d, input int e, input int f);
    u_if.d1 = 4'(a);
    u_if.d2 = 4'(b);
    u_if.d3 = 4'(c);
    u_if.d4 = 4'(d);
    u_if.d5 = 4'(e);
    u_if.d6 = 4'(f);
  endtask

  task automatic model_reset();
    t = -1;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'hF;
    m_hide = 1'b0;
    m_dp   = 6'h00;
    m_k    = -1;
    m_dark = 1'b0;
  endtask

  // One clock: update model at the edge, compare all outputs at the falling edge.
  task automatic tick();
    int         off;
    int         slot;
    bit         drive;
    logic [3:0] code;
    logic [7:0] exp_seg;
    logic [5:0] exp_an;
    @(posedge clk);
    t++;
    if (t % FRAME == 0) begin
      m_snap = '{u_if.d1, u_if.d2, u_if.d3, u_if.d4, u_if.d5, u_if.d6};
      m_hide = u_if.hide;
`ifdef SCANNER_DP_EN
      m_dp = u_if.dp_mask;
`endif
      if (u_if.blink) begin
        m_k++;
        m_dark = ((m_k / BLINK_FRAMES) % 2) == 1;
      end else begin
        m_k    = -1;
        m_dark = 1'b0;
      end
    end
    @(negedge clk);
    off   = t % SCAN_DIV;
    slot  = (t / SCAN_DIV) % 6;
    drive = (off >= DEAD);
    code  = m_snap[slot];
    exp_seg = 8'hFF;
    if (drive) begin
      exp_seg[6:0] = (m_hide && code < 4'd14) ? 7'h3F : seg_tab[code];
      exp_seg[7]   = ~m_dp[slot];
    end
    for (int i = 0; i < 6; i++) exp_an[i] = !(drive && !m_dark && i == slot);
    check("seg", u_if.seg, exp_seg);
    check("an", {2'b00, u_if.an}, {2'b00, exp_an});
    check("frame_tick", {7'b0, u_if.frame_tick}, {7'b0, (t % FRAME == 0)});
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  initial begin
    model_reset();
    set_digits(1, 2, 3, 4, 5, 6);
    u_if.hide  = 1'b0;
    u_if.blink = 1'b0;
`ifdef SCANNER_DP_EN
    u_if.dp_mask = 6'h00;
`endif
    clr_n = 1'b0;
    #12;
    check("reset_seg", u_if.seg, 8'hFF);
    check("reset_an", {2'b00, u_if.an}, 8'h3F);
    check("reset_tick", {7'b0, u_if.frame_tick}, 8'h00);
    @(negedge clk);
    clr_n = 1'b1;

    run_to(0);
    check("c0_tick", {7'b0, u_if.frame_tick}, 8'h01);
    check("c0_an", {2'b00, u_if.an}, 8'h3F);
    run_to(2);
    check("c2_an", {2'b00, u_if.an}, 8'h3E);
    check("c2_seg", u_if.seg, 8'hF9);
    run_to(5);
    u_if.d1 = 4'd8;
    run_to(7);
    check("c7_seg_old", u_if.seg, 8'hF9);
    run_to(10);
    check("c10_an", {2'b00, u_if.an}, 8'h3D);
    check("c10_seg", u_if.seg, 8'hA4);

    run_to(40);
    u_if.blink = 1'b1;
    run_to(48);
    check("c48_tick", {7'b0, u_if.frame_tick}, 8'h01);
    run_to(50);
    check("c50_seg_new", u_if.seg, 8'h80);
    check("c50_an", {2'b00, u_if.an}, 8'h3E);
    run_to(98);
    check("c98_an_lit", {2'b00, u_if.an}, 8'h3E);
    run_to(146);
    check("c146_an_dark", {2'b00, u_if.an}, 8'h3F);
    check("c146_seg", u_if.seg, 8'h80);
    run_to(239);
    check("c239_an_dark", {2'b00, u_if.an}, 8'h3F);
    run_to(242);
    check("c242_an_lit", {2'b00, u_if.an}, 8'h3E);
    run_to(340);
    u_if.blink = 1'b0;
    run_to(386);
    check("c386_an_unblink", {2'b00, u_if.an}, 8'h3E);

    run_to(390);
    set_digits(14, 14, 14, 14, 14, 14);
    u_if.hide = 1'b1;
    run_to(434);
    check("e_hide_slot0", u_if.seg, 8'h86);
    run_to(450);
    check("e_hide_slot2", u_if.seg, 8'h86);
    check("e_hide_an2", {2'b00, u_if.an}, 8'h3B);
    set_digits(7, 11, 15, 0, 9, 3);
    run_to(482);
    check("hide_7", u_if.seg, 8'hBF);
    run_to(498);
    check("hide_15", u_if.seg, 8'hFF);
    run_to(510);
    check("hide_0", u_if.seg, 8'hBF);
    check("slot3_an", {2'b00, u_if.an}, 8'h37);

    #2;
    clr_n = 1'b0;
    #1;
    check("midrst_seg", u_if.seg, 8'hFF);
    check("midrst_an", {2'b00, u_if.an}, 8'h3F);
    check("midrst_tick", {7'b0, u_if.frame_tick}, 8'h00);
    model_reset();
    set_digits(1, 2, 3, 4, 5, 6);
    u_if.hide = 1'b0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    run_to(0);
    check("rst2_tick", {7'b0, u_if.frame_tick}, 8'h01);
    run_to(2);
    check("rst2_seg", u_if.seg, 8'hF9);

`ifdef SCANNER_DP_EN
    run_to(5);
    u_if.dp_mask = 6'b000100;
    run_to(58);
    check("dp_slot1", {7'b0, u_if.seg[7]}, 8'h01);
    run_to(65);
    check("dp_blank", {7'b0, u_if.seg[7]}, 8'h01);
    run_to(66);
    check("dp_slot2", {7'b0, u_if.seg[7]}, 8'h00);
    check("dp_an", {2'b00, u_if.an}, 8'h3B);
`endif

    // randomized traffic: digits/hide change any cycle, blink at most once per frame
    for (int c = 0; c < 20 * FRAME; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        u_if.hide = 1'($urandom_range(0, 1));
`ifdef SCANNER_DP_EN
        u_if.dp_mask = 6'($urandom_range(0, 63));
`endif
      end
      if ((t % FRAME) == 20) u_if.blink = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/six_digit_display_scanner.md
Name: six_digit_display_scanner

Overview:
Consumer end of the lock controller's six-digit output bus (out1..out6, 4-bit codes). The block latches the six codes once per display frame and decodes each to 7-segment patterns. It time-multiplexes them onto a common-anode 6-digit display, with dead-time blanking between digits, masking when hidden, and whole-display blinking for the lockout alarm. It sits between the lock controller and the board's segment/anode pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (must be >= 2)
DEAD, 500, blanked cycles at the start of each slot; 0 <= DEAD < SCAN_DIV; 0 means no blanking
BLINK_FRAMES, 64, frames per blink half-period (must be >= 1)
DIV_W, 16, prescaler width; must satisfy 2^DIV_W >= SCAN_DIV

Ports:
clk  in  1  system clock
clr_n  in  1  asynchronous active-low reset
d1..d6  in  4 each  digit codes: 0-9 numeric, 10-13 dash, 14 (4'b1110) 'E', 15 blank
hide  in  1  mask numeric digits
blink  in  1  alarm; flash the whole display
seg  out  8  active-low {dp,g,f,e,d,c,b,a}
an  out  6  active-low digit enables; an[i] drives digit i+1
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (clr_n=0, asynchronous): seg=8'hFF, an=6'h3F, frame_tick=0, slot=0, prescaler=0, snapshot regs=4'hF, blink phase=0, frame counter=0. These take effect immediately, including mid-frame.
- Timing: the first rising clk edge after clr_n rises is cycle 0 of slot 0. The prescaler counts 0..SCAN_DIV-1. On SCAN_DIV-1 it wraps to 0 and the slot increments 0..5; slot 5 wraps to 0. Frame length = 6*SCAN_DIV cycles.
- FSM per slot: BLANK for cycles 0..DEAD-1, with an=6'h3F and seg=8'hFF. DRIVE for cycles DEAD..SCAN_DIV-1, with an[slot]=0, other an bits 1, and seg=decode(snapshot[slot]). BLANK -> DRIVE when cycle==DEAD. DRIVE -> BLANK at slot wrap. If DEAD=0, BLANK is skipped.
- Outputs are registered. Their values must match the above cycle numbering exactly, and no glitch is allowed where two an bits are low in the same cycle.
- Snapshot: on cycle 0 of slot 0, the block captures d1..d6 and hide into internal registers and asserts frame_tick for that one cycle. Input changes mid-frame have no visible effect until the next frame.
- Decode (seg[6:0], active-low gfedcba):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex)
  - 10-13 dash=3F; 14 E=06; 15 blank=7F
  - dp (seg[7]) = 1
- Hide: when latched hide=1, codes 0-13 display as dash (3F). E and blank are unchanged.
- Blink: the frame counter counts frame starts 0..BLINK_FRAMES-1, and the blink phase toggles on wrap.
  - While blink=0: frame counter and phase are held at 0 synchronously.
  - While blink=1 and phase=1: an is forced to 6'h3F for the whole frame. The FSM, seg and frame_tick are unaffected.
  - Frame counter, phase and the an force update only at frame boundaries.
- Simultaneous events: snapshot and blink-phase update on the same edge both apply. The new phase governs the frame beginning at that edge.

Optional Feature:
SCANNER_DP_EN: adds input dp_mask [5:0]. dp_mask is latched with the snapshot. During DRIVE, seg[7] = ~dp_mask_latched[slot]; in BLANK, seg[7]=1.
Without the macro: no dp_mask port, and seg[7] is constantly 1.

Test Plan:
- SCAN_DIV=8, DEAD=2, BLINK_FRAMES=2.
  - Reset then d1..d6=1,2,3,4,5,6: cycles 0-1 an=3F/seg=FF; cycles 2-7 an=3E/seg=F9; cycles 10-15 an=3D/seg=A4; frame_tick high at cycles 0, 48, 96.
  - Change d1 to 8 at cycle 5: slot 0 still shows F9 until cycle 49; from cycle 50, seg=80 on an=3E.
  - d1..d6=14,14,14,14,14,14 with hide=1: every DRIVE shows seg=86. Then d=7,11,15,0,9,3 with hide=1: seg=BF,BF,FF,BF,BF,BF across slots.
  - blink=1 asserted before frame start at cycle 48: frames at 48 and 96 show normal an. Phase toggles at the frame start at cycle 144, so an=3F throughout cycles 144-239. Normal an resumes from cycle 240. Deasserting blink returns phase to 0, and an is normal from the next frame.
  - Assert clr_n=0 asynchronously mid-DRIVE of slot 3 (cycle 30.5): seg=FF and an=3F immediately. After release, timing restarts at slot 0, cycle 0, with snapshot 15 (blank) until the first capture.
- SCANNER_DP_EN, dp_mask=6'b000100: seg[7]=0 only during DRIVE of slot 2 (an=3B), and 1 in all other slots and in BLANK.
